// File: rtl/uart_rx_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_splitter                                                  |
// | Brief  : Decodes the host 8N1 RX line and splits it into monitor command   |
// |          strobes (SYNC, CMD, ARG frames) and a re-serialized 8N1 stream    |
// |          carrying every other byte on to CROC.                             |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module uart_rx_splitter #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_host,
  output logic       rx_croc,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       frame_err,
  output logic       fifo_ovf
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int c_BW      = $clog2(CLKS_PER_BIT);
  localparam int c_TIMEOUT = 20 * CLKS_PER_BIT;
  localparam int c_TW      = $clog2(c_TIMEOUT + 1);
  localparam int c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_HALF_LAST = c_BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_TW-1:0] c_TO_LIMIT  = c_TW'(c_TIMEOUT);
  localparam logic [c_AW-1:0] c_PTR_LAST  = c_AW'(FIFO_DEPTH - 1);
  localparam logic [c_CW-1:0] c_FIFO_FULL = c_CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_WAIT  = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_CMD  = 2'd1,
    P_ARG  = 2'd2
  } p_state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_host;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // ---------------------------------------------------------------------------
  // RX deserializer
  // ---------------------------------------------------------------------------
  rx_state_t       r_rx_state;
  rx_state_t       w_rx_next;
  logic [c_BW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_tick;
  logic            w_rx_half;
  logic            w_byte_valid;
  logic            w_stop_err;

  assign w_rx_tick = (r_rx_cnt == c_BIT_LAST);
  assign w_rx_half = (r_rx_cnt == c_HALF_LAST);

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= R_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  // RX next-state and byte-complete / stop-error decode.
  always_comb begin
    w_rx_next    = r_rx_state;
    w_byte_valid = 1'b0;
    w_stop_err   = 1'b0;
    case (r_rx_state)
      // The line is known high here (R_WAIT guarantees it), so low == falling edge.
      R_IDLE:  if (!w_rx) w_rx_next = R_START;
      R_START: if (w_rx_half) w_rx_next = w_rx ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = R_STOP;
      R_STOP: begin
        if (w_rx_tick) begin
          if (w_rx) begin
            w_byte_valid = 1'b1;
            w_rx_next    = R_IDLE;
          end else begin
            w_stop_err   = 1'b1;
            w_rx_next    = R_WAIT;
          end
        end
      end
      R_WAIT:  if (w_rx) w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  // RX bit timer and data shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      if ((r_rx_state != w_rx_next) || (r_rx_state == R_IDLE) || (r_rx_state == R_WAIT)) begin
        r_rx_cnt <= '0;
      end else if ((r_rx_state == R_DATA) && w_rx_tick) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + c_BW'(1);
      end

      if (r_rx_state == R_START) begin
        r_rx_bit <= 3'd0;
      end else if ((r_rx_state == R_DATA) && w_rx_tick) begin
        r_rx_bit   <= r_rx_bit + 3'd1;
        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  p_state_t        r_p_state;
  p_state_t        w_p_eff;
  p_state_t        w_p_next;
  logic [c_TW-1:0] r_to_cnt;
  logic [7:0]      r_cmd_byte;
  logic            w_timeout;
  logic            w_push;
  logic [7:0]      w_push_data;
  logic            w_cmd_latch;
  logic            w_cmd_fire;

  assign w_timeout = (r_p_state != P_IDLE) && (r_to_cnt == c_TO_LIMIT);

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_state <= P_IDLE;
    end else begin
      r_p_state <= w_p_next;
    end
  end

  // Parser next-state; a timeout abandons the frame before the byte is looked at.
  always_comb begin
    w_p_eff     = w_timeout ? P_IDLE : r_p_state;
    w_p_next    = w_p_eff;
    w_push      = 1'b0;
    w_push_data = r_rx_shift;
    w_cmd_latch = 1'b0;
    w_cmd_fire  = 1'b0;
    if (w_byte_valid) begin
      case (w_p_eff)
        P_IDLE: begin
          if (r_rx_shift == SYNC_BYTE) w_p_next = P_CMD;
          else                         w_push   = 1'b1;
        end
        P_CMD: begin
          if (r_rx_shift == SYNC_BYTE) begin
            // Doubled SYNC is an escaped literal SYNC byte for CROC.
            w_push      = 1'b1;
            w_push_data = SYNC_BYTE;
            w_p_next    = P_IDLE;
          end else begin
            w_cmd_latch = 1'b1;
            w_p_next    = P_ARG;
          end
        end
        P_ARG: begin
          w_cmd_fire = 1'b1;
          w_p_next   = P_IDLE;
        end
        default: w_p_next = P_IDLE;
      endcase
    end
  end

  // Inter-byte timeout counter and CMD byte holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt   <= '0;
      r_cmd_byte <= 8'h00;
    end else begin
      if (w_byte_valid || (w_p_next == P_IDLE)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + c_TW'(1);
      end
      if (w_cmd_latch) begin
        r_cmd_byte <= r_rx_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forward FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push_ok;
  logic [7:0]      w_fifo_head;

  assign w_full      = (r_count == c_FIFO_FULL);
  assign w_empty     = (r_count == '0);
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_fifo_head = r_mem[r_rd_ptr];

  // FIFO storage; data needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  tx_state_t       r_tx_state;
  tx_state_t       w_tx_next;
  logic [c_BW-1:0] r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_tx_line;
  logic            w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  // TX next-state; the end of a stop bit chains straight into the next start bit.
  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_tx_next = T_START;
        end
      end
      T_START: if (w_tx_tick) w_tx_next = T_DATA;
      T_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = T_STOP;
      T_STOP: begin
        if (w_tx_tick) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_tx_next = T_START;
          end else begin
            w_tx_next = T_IDLE;
          end
        end
      end
      default: w_tx_next = T_IDLE;
    endcase
  end

  // TX bit timer, shift register and registered line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          r_tx_cnt <= '0;
          if (w_pop) begin
            r_tx_shift <= w_fifo_head;
            r_tx_line  <= 1'b0;
          end
        end
        T_START: begin
          if (w_tx_tick) begin
            r_tx_cnt  <= '0;
            r_tx_bit  <= 3'd0;
            r_tx_line <= r_tx_shift[0];
          end else begin
            r_tx_cnt  <= r_tx_cnt + c_BW'(1);
          end
        end
        T_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_tx_line  <= 1'b1;
            end else begin
              r_tx_line  <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_BW'(1);
          end
        end
        T_STOP: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (w_pop) begin
              r_tx_shift <= w_fifo_head;
              r_tx_line  <= 1'b0;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_BW'(1);
          end
        end
        default: begin
          r_tx_cnt  <= '0;
          r_tx_line <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic       r_cmd_valid;
  logic [7:0] r_cmd_code;
  logic [7:0] r_cmd_arg;
  logic       r_frame_err;
  logic       r_fifo_ovf;

  // Command strobe, held command fields and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 8'h00;
      r_cmd_arg   <= 8'h00;
      r_frame_err <= 1'b0;
      r_fifo_ovf  <= 1'b0;
    end else begin
      r_cmd_valid <= w_cmd_fire;
      if (w_cmd_fire) begin
        r_cmd_code <= r_cmd_byte;
        r_cmd_arg  <= r_rx_shift;
      end
      r_frame_err <= w_stop_err | w_timeout;
      r_fifo_ovf  <= w_push & ~w_push_ok;
    end
  end

  assign rx_croc   = r_tx_line;
  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_arg   = r_cmd_arg;
  assign frame_err = r_frame_err;
  assign fifo_ovf  = r_fifo_ovf;

endmodule
`default_nettype wire

// File: doc/uart_rx_splitter.md
# uart_rx_splitter

Receive-side counterpart of the shared debug UART. Decodes the single host RX line (8N1) and splits it into two streams. Monitor command frames (SYNC, CMD, ARG) go to the aging monitor as a one-cycle command strobe. All other bytes are re-serialized onto a clean RX line for CROC. Sits between the board RX pin and both CROC's UART RX and the aging monitor's command port.

## Interface
- `CLKS_PER_BIT`, 434, clocks per UART bit; 50 MHz / 115200 baud; must be ≥ 8.
- `SYNC_BYTE`, 8'hA5, byte that opens a monitor command frame.
- `FIFO_DEPTH`, 4, depth of the CROC forward FIFO; power of two.
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_host` in 1: raw host UART line; asynchronous; idle high.
- `rx_croc` out 1: re-serialized 8N1 line to CROC, same baud; idle high.
- `cmd_valid` out 1: one-cycle strobe; a complete monitor frame was received.
- `cmd_code` out 8: CMD byte of the frame; held until the next strobe.
- `cmd_arg` out 8: ARG byte of the frame; held until the next strobe.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low, or a command frame timed out.
- `fifo_ovf` out 1: one-cycle pulse; a forward byte was dropped because the FIFO was full.

## Operation
- **Reset values:** `rx_croc`=1, `cmd_valid`=0, `cmd_code`=0, `cmd_arg`=0, `frame_err`=0, `fifo_ovf`=0. FIFO is emptied and all FSMs go idle. Reset asserted mid-byte aborts both RX and TX; `rx_croc` goes high asynchronously.
- **Input sync:** `rx_host` passes through a 2-FF synchronizer; all decoding uses the synchronized value.
- **RX FSM (R_IDLE, R_START, R_DATA, R_STOP, R_WAIT):**
  - R_IDLE: falling edge starts R_START.
  - R_START: samples at CLKS_PER_BIT/2. If the line is high, the start is a glitch; return to R_IDLE.
  - R_DATA: samples 8 bits LSB first, one every CLKS_PER_BIT.
  - R_STOP: samples the stop bit. High produces an internal `byte_valid` pulse. Low pulses `frame_err`, discards the byte, and goes to R_WAIT.
  - R_WAIT: holds until the line is high, then returns to R_IDLE.
- **Parser FSM (P_IDLE, P_CMD, P_ARG):** acts only on `byte_valid`.
  - P_IDLE: byte == SYNC_BYTE goes to P_CMD. Any other byte is pushed to the FIFO.
  - P_CMD: byte == SYNC_BYTE is an escape. Push a literal SYNC_BYTE to the FIFO and return to P_IDLE. Otherwise latch the byte as cmd and go to P_ARG.
  - P_ARG: latch the byte as arg (any value, SYNC_BYTE included). Update `cmd_code`/`cmd_arg`, pulse `cmd_valid`, and return to P_IDLE.
  - Timeout: in P_CMD or P_ARG, a counter runs from the last accepted byte. Reaching 20·CLKS_PER_BIT clocks returns the parser to P_IDLE and pulses `frame_err`. The partial frame is discarded, not forwarded.
  - A framing-error byte does not advance or reset the parser state.
- **FIFO:** holds FIFO_DEPTH bytes.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `fifo_ovf` pulses.
  - Order is preserved.
- **TX FSM (T_IDLE, T_START, T_DATA, T_STOP):**
  - T_IDLE: pops when the FIFO is non-empty.
  - T_START: drives start bit 0.
  - T_DATA: drives 8 data bits LSB first, CLKS_PER_BIT clocks each.
  - T_STOP: drives stop bit 1 for one bit period, then returns to T_IDLE.
  - Back-to-back bytes carry no extra idle.

## Timing
- Stop-bit sample is at cycle S; `byte_valid` is high in cycle S.
- `cmd_valid`, `cmd_code`, `cmd_arg`, `frame_err` (stop error) and `fifo_ovf` are registered and visible in S+1.
- Forwarded byte with TX idle: FIFO non-empty in S+1, pop in S+1, `rx_croc`=0 from S+2.
- `rx_host` to internal sample latency is 2 clocks (synchronizer).
- Timeout `frame_err` is visible the cycle after the counter reaches 20·CLKS_PER_BIT.
- A byte completing in the same cycle the timeout fires: the timeout wins, and the byte is parsed from P_IDLE.
- Forward throughput equals line rate. The FIFO absorbs the rate slack that escapes introduce.

## Test plan
Run with CLKS_PER_BIT=8.
1. Send 0x41 -> `rx_croc` carries 0x41 8N1, start bit 2 clocks after the stop sample; `cmd_valid` stays 0.
2. Send A5 03 7F -> a single `cmd_valid` with `cmd_code`=0x03, `cmd_arg`=0x7F; `rx_croc` stays high throughout.
3. Send A5 A5 then 0x10 -> `rx_croc` carries A5 then 10; no `cmd_valid`.
4. Send A5 03, then idle 200 clocks, then 0x42 -> `frame_err` pulses once at the timeout; 0x42 is forwarded; no `cmd_valid`.
5. Send a byte with its stop bit forced low, then 0x55 -> `frame_err` pulses; only 0x55 appears on `rx_croc`.
6. Send 6 bytes back-to-back at a 1% faster host baud, FIFO_DEPTH=2 -> all forwarded in order, or `fifo_ovf` pulses for each drop. Separately, assert `rst` mid-TX -> `rx_croc`=1 immediately, and the FIFO is empty after release.
